// File: rtl/moddiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moddiv_pkg
// Description : Shared types and sizing helpers for the runtime-modulus
//               modular divider (moddiv_engine and mod_half_sub).
//               - state_t : engine FSM states
//               - err_t   : completion status reported on err_code
//               - max_iter: watchdog limit on RUN steps for a given width
//               - cnt_w   : iteration counter width for a given width
// Revision    : 1.0 - initial release
// ============================================================================
package moddiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_NOINV   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    // Binary extended Euclid needs at most about 2*DATA_LEN steps; the
    // watchdog leaves a comfortable margin above that.
    function automatic int max_iter(input int data_len);
        return 4 * data_len + 4;
    endfunction

    function automatic int cnt_w(input int data_len);
        return $clog2(max_iter(data_len) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_half_sub.sv
`default_nettype none
// ============================================================================
// Module      : mod_half_sub
// Description : Combinational modular helpers for an odd modulus p.
//               half(a)   = a/2 mod p        (a < p)
//               msub(a,b) = (a - b) mod p    (a, b < p)
// Ports       : i_p               modulus (odd)
//               i_half_a          operand of half()
//               i_sub_a, i_sub_b  operands of msub()
//               o_half_y          half() result, < p
//               o_sub_y           msub() result, < p
// Revision    : 1.0 - initial release
// ============================================================================
module mod_half_sub #(
    parameter int DATA_LEN = 256
) (
    input  logic [DATA_LEN-1:0] i_p,
    input  logic [DATA_LEN-1:0] i_half_a,
    input  logic [DATA_LEN-1:0] i_sub_a,
    input  logic [DATA_LEN-1:0] i_sub_b,
    output logic [DATA_LEN-1:0] o_half_y,
    output logic [DATA_LEN-1:0] o_sub_y
);

    localparam logic [DATA_LEN-1:0] c_one = DATA_LEN'(1);

    logic [DATA_LEN:0] w_diff;

    // For odd a and odd p, (a + p) >> 1 == (a >> 1) + (p >> 1) + 1, so the
    // carry bit of a+p never has to be materialised. The result is < p.
    assign o_half_y = i_half_a[0] ? ((i_half_a >> 1) + (i_p >> 1) + c_one)
                                  : (i_half_a >> 1);

    // The borrow out of a-b selects the +p correction; the add wraps modulo
    // 2^DATA_LEN, which lands exactly on a-b+p.
    assign w_diff  = {1'b0, i_sub_a} - {1'b0, i_sub_b};
    assign o_sub_y = w_diff[DATA_LEN-1:0] + (w_diff[DATA_LEN] ? i_p : '0);

endmodule
`default_nettype wire

// File: rtl/moddiv_engine.sv
`default_nettype none
// ============================================================================
// Module      : moddiv_engine
// Description : Runtime-modulus modular divider q = x * y^-1 mod p using a
//               binary extended Euclid datapath, one step per RUN cycle.
// Ports       : clk, rst        clock (rising edge), synchronous active-high reset
//               start, abort    request (taken when ready) / cancel in flight
//               x_in, y_in      dividend and divisor, both < p_in
//               p_in            odd modulus >= 3, sampled at accept
//               ready, busy     in IDLE / in RUN
//               done            one-cycle completion pulse (success or error)
//               err_code        0 NONE, 1 RANGE, 2 NOINV, 3 TIMEOUT
//               q_out           quotient, 0 on error
//               iter_cnt        steps used by the last operation
// Revision    : 1.0 - initial release
// ============================================================================
module moddiv_engine
    import moddiv_pkg::*;
#(
    parameter  int DATA_LEN = 256,
    localparam int MAX_ITER = max_iter(DATA_LEN),
    localparam int CNT_W    = cnt_w(DATA_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_LEN-1:0] x_in,
    input  logic [DATA_LEN-1:0] y_in,
    input  logic [DATA_LEN-1:0] p_in,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code,
    output logic [DATA_LEN-1:0] q_out,
    output logic [CNT_W-1:0]    iter_cnt
);

    localparam logic [CNT_W-1:0]    c_max_iter = CNT_W'(MAX_ITER);
    localparam logic [DATA_LEN-1:0] c_one      = DATA_LEN'(1);
    localparam logic [DATA_LEN-1:0] c_three    = DATA_LEN'(3);

    state_t              r_state;
    logic                r_entry;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    err_t                r_err;
    logic [CNT_W-1:0]    r_iter;
    logic [DATA_LEN-1:0] r_p;
    logic [DATA_LEN-1:0] r_u;
    logic [DATA_LEN-1:0] r_v;
    logic [DATA_LEN-1:0] r_m;
    logic [DATA_LEN-1:0] r_n;
    logic [DATA_LEN-1:0] r_q;

    logic                w_range_bad;
    logic                w_u_even;
    logic                w_v_even;
    logic                w_u_ge_v;
    logic [DATA_LEN-1:0] w_half_a;
    logic [DATA_LEN-1:0] w_sub_a;
    logic [DATA_LEN-1:0] w_sub_b;
    logic [DATA_LEN-1:0] w_half_y;
    logic [DATA_LEN-1:0] w_sub_y;

    assign w_range_bad = ~p_in[0] | (p_in < c_three) | (x_in >= p_in) | (y_in >= p_in);

    assign w_u_even = ~r_u[0];
    assign w_v_even = ~r_v[0];
    assign w_u_ge_v = (r_u >= r_v);

    // One shared helper instance. half() acts on m when u is even, otherwise
    // on n (the v-even step). msub() pairs (m,n) when u>=v, else (n,m).
    assign w_half_a = w_u_even ? r_m : r_n;
    assign w_sub_a  = w_u_ge_v ? r_m : r_n;
    assign w_sub_b  = w_u_ge_v ? r_n : r_m;

    mod_half_sub #(
        .DATA_LEN (DATA_LEN)
    ) u_mod_half_sub (
        .i_p      (r_p),
        .i_half_a (w_half_a),
        .i_sub_a  (w_sub_a),
        .i_sub_b  (w_sub_b),
        .o_half_y (w_half_y),
        .o_sub_y  (w_sub_y)
    );

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err_code = r_err;
    assign q_out    = r_q;
    assign iter_cnt = r_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_entry <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= ERR_NONE;
            r_iter  <= '0;
            r_p     <= '0;
            r_u     <= '0;
            r_v     <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_p     <= p_in;
                        r_iter  <= '0;
                        r_q     <= '0;
                        r_ready <= 1'b0;
                        if (w_range_bad) begin
                            r_err   <= ERR_RANGE;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_err   <= ERR_NONE;
                            r_u     <= y_in;
                            r_v     <= p_in;
                            r_m     <= x_in;
                            r_n     <= '0;
                            r_entry <= 1'b1;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        r_entry <= 1'b0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (r_entry) begin
                        // Entry cycle: the freshly loaded operands settle in
                        // the datapath registers and no step is taken, which
                        // gives the fixed two-edge minimum latency.
                        r_entry <= 1'b0;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                        if (r_u == c_one) begin
                            r_q     <= r_m;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_v == c_one) begin
                            r_q     <= r_n;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if ((r_u == '0) || (r_v == '0)) begin
                            // gcd(y,p) != 1: u and v met without reaching 1.
                            r_err   <= ERR_NOINV;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_iter == c_max_iter) begin
                            r_err   <= ERR_TIMEOUT;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_u_even) begin
                            r_u <= r_u >> 1;
                            r_m <= w_half_y;
                        end else if (w_v_even) begin
                            r_v <= r_v >> 1;
                            r_n <= w_half_y;
                        end else if (w_u_ge_v) begin
                            r_u <= r_u - r_v;
                            r_m <= w_sub_y;
                        end else begin
                            r_v <= r_v - r_u;
                            r_n <= w_sub_y;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_entry <= 1'b0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_moddiv_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_moddiv_engine
// Description : Self-checking bench for moddiv_engine (DATA_LEN=256).
//               Stimulus pushes expected results into a scoreboard queue;
//               a monitor pops and compares whenever done is seen. Expected
//               quotients come from an extended-Euclid reference model using
//               plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moddiv_engine;
    import moddiv_pkg::*;

    localparam int DL   = 256;
    localparam int MAXI = max_iter(DL);
    localparam int CW   = cnt_w(DL);
    localparam logic [DL-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DL-1:0] x_in;
    logic [DL-1:0] y_in;
    logic [DL-1:0] p_in;
    logic          ready;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;
    logic [DL-1:0] q_out;
    logic [CW-1:0] iter_cnt;

    moddiv_engine #(
        .DATA_LEN (DL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .x_in     (x_in),
        .y_in     (y_in),
        .p_in     (p_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .err_code (err_code),
        .q_out    (q_out),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // lat / iter of -1 mean "not fixed": iter is then only range-checked.
    typedef struct {
        logic [1:0]    err;
        logic [DL-1:0] q;
        int            lat;
        int            iter;
        int            acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DL-1:0] mulmod(input logic [DL-1:0] a, input logic [DL-1:0] b,
                                             input logic [DL-1:0] m);
        logic [2*DL-1:0] t;
        t = {{DL{1'b0}}, a} * {{DL{1'b0}}, b};
        t = t % {{DL{1'b0}}, m};
        return t[DL-1:0];
    endfunction

    task automatic ref_model(input logic [DL-1:0] x, input logic [DL-1:0] y, input logic [DL-1:0] p,
                             output logic [1:0] err, output logic [DL-1:0] q);
        logic [DL-1:0] r0, r1, rn, qq, t0, t1;
        logic [DL:0]   s;
        if (!p[0] || p < DL'(3) || x >= p || y >= p) begin
            err = 2'd1;
            q   = '0;
        end else begin
            // Invariant: t_i * y == r_i (mod p)
            r0 = p;  r1 = y;
            t0 = '0; t1 = DL'(1);
            while (r1 != '0) begin
                qq = r0 / r1;
                rn = r0 - qq * r1;
                r0 = r1;
                r1 = rn;
                s  = {1'b0, t0} + {1'b0, p} - {1'b0, mulmod(qq, t1, p)};
                s  = s % {1'b0, p};
                t0 = t1;
                t1 = s[DL-1:0];
            end
            if (r0 != DL'(1)) begin
                err = 2'd2;
                q   = '0;
            end else begin
                err = 2'd0;
                q   = mulmod(x, t0, p);
            end
        end
    endtask

    function automatic logic [DL-1:0] rand_wide();
        logic [DL-1:0] r;
        r = '0;
        for (int k = 0; k < DL / 32; k++) r = {r[DL-33:0], 32'($urandom())};
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", DL'(1), DL'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("err_code", DL'(err_code), DL'(mon_e.err));
                chk("q_out", q_out, mon_e.q);
                if (mon_e.lat >= 0) chk("latency", DL'(cyc - mon_e.acc), DL'(mon_e.lat));
                if (mon_e.iter >= 0) chk("iter_cnt", DL'(iter_cnt), DL'(mon_e.iter));
                else chk("iter_bound", DL'(iter_cnt >= 1 && iter_cnt <= MAXI), DL'(1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < MAXI + 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", DL'(ready), DL'(1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < MAXI + 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", DL'(sb_q.size()), DL'(0));
        sb_q.delete();
    endtask

    task automatic issue(input logic [DL-1:0] xi, input logic [DL-1:0] yi, input logic [DL-1:0] pi,
                         input int lat, input int iter);
        logic [1:0]    e_err;
        logic [DL-1:0] e_q;
        exp_t          e;
        wait_ready();
        x_in  = xi;
        y_in  = yi;
        p_in  = pi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ref_model(xi, yi, pi, e_err, e_q);
        e.err  = e_err;
        e.q    = e_q;
        e.lat  = lat;
        e.iter = iter;
        e.acc  = cyc;
        if (e_err == 2'd1) begin
            e.lat  = 0;
            e.iter = 0;
        end
        sb_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, DL'(ready), DL'(1));
        chk({tag, "_busy"}, DL'(busy), DL'(0));
        chk({tag, "_done"}, DL'(done), DL'(0));
        chk({tag, "_err"}, DL'(err_code), DL'(0));
        chk({tag, "_q"}, q_out, DL'(0));
        chk({tag, "_iter"}, DL'(iter_cnt), DL'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        x_in  = '0;
        y_in  = '0;
        p_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        issue(DL'(1), DL'(2), DL'(251), -1, -1);
        wait_drain();
        chk("q_1_over_2", q_out, DL'(126));
        issue(DL'(10), DL'(3), DL'(251), -1, -1);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("q_hold_87", q_out, DL'(87));
        chk("err_hold", DL'(err_code), DL'(0));
        issue(DL'(7), DL'(1), DL'(251), 2, 1);
        wait_drain();
        chk("q_y1", q_out, DL'(7));
        issue(DL'(5), DL'(3), DL'(250), 0, 0);
        wait_drain();
        chk("err_even_p", DL'(err_code), DL'(1));
        issue(DL'(251), DL'(3), DL'(251), 0, 0);
        wait_drain();
        issue(DL'(3), DL'(6), DL'(9), -1, -1);
        wait_drain();
        chk("err_noinv", DL'(err_code), DL'(2));
        issue(DL'(5), DL'(0), DL'(251), 2, 1);
        wait_drain();

        // start with abort in IDLE is ignored
        wait_ready();
        x_in  = DL'(7);
        y_in  = DL'(1);
        p_in  = DL'(251);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_idle_ready", DL'(ready), DL'(1));
        chk("abort_idle_busy", DL'(busy), DL'(0));
        start = 1'b0;
        abort = 1'b0;
        repeat (6) @(negedge clk);

        // abort 3 cycles after accept
        wait_ready();
        x_in  = DL'(10);
        y_in  = DL'(3);
        p_in  = DL'(251);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("run_busy", DL'(busy), DL'(1));
        chk("run_ready", DL'(ready), DL'(0));
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_ready", DL'(ready), DL'(1));
        chk("abort_busy", DL'(busy), DL'(0));
        chk("abort_err", DL'(err_code), DL'(0));
        chk("abort_q", q_out, DL'(0));
        repeat (20) @(negedge clk);
        issue(DL'(10), DL'(3), DL'(251), -1, -1);
        wait_drain();
        chk("after_abort_q", q_out, DL'(87));

        // reset 5 cycles into RUN
        wait_ready();
        x_in  = DL'(10);
        y_in  = DL'(3);
        p_in  = DL'(251);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrun_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // back-to-back with start held high: second accept only after DONE
        wait_ready();
        x_in  = DL'(7);
        y_in  = DL'(1);
        p_in  = DL'(251);
        start = 1'b1;
        @(posedge clk);
        #1;
        e.err  = 2'd0;
        e.q    = DL'(7);
        e.iter = 1;
        e.acc  = cyc;
        e.lat  = 2;
        sb_q.push_back(e);
        e.lat  = 6;
        sb_q.push_back(e);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);

        // random small moduli, including composites and out-of-range operands
        for (int i = 0; i < 150; i++) begin
            int pv;
            int xv;
            int yv;
            pv = int'($urandom_range(3, 255));
            if (i % 10 != 0) pv = pv | 1;
            xv = int'($urandom_range(0, pv - 1));
            yv = int'($urandom_range(0, pv - 1));
            if (i % 13 == 0) xv = pv;
            issue(DL'(xv), DL'(yv), DL'(pv), -1, -1);
        end
        wait_drain();

        // random SM2 operands
        for (int i = 0; i < 40; i++) begin
            logic [DL-1:0] a;
            logic [DL-1:0] b;
            a = rand_wide() % SM2_P;
            b = rand_wide() % SM2_P;
            if (b == '0) b = DL'(1);
            issue(a, b, SM2_P, -1, -1);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
